sw_debouncer: RTL and testbench
===============================

# sw_debouncer

Multi-channel switch debouncer that sits directly upstream of the rotating-square display stage. It conditions the raw board slide switches (`sw`) into clean, synchronised levels that drive that stage's enable and direction inputs, plus single-cycle edge ticks for any consumer needing event semantics. Each channel uses a two-flop synchroniser followed by a four-state FSM with a per-channel stability counter.

## Interface
- `W`, default 2: number of independent switch channels.
- `N`, default 20: stability counter width. The debounce window is 2^N clock cycles, about 10.5 ms at 100 MHz.

- `clk`  input  1: system clock; all state updates on the rising edge.
- `reset_n`  input  1: reset. Asynchronous, active-low.
- `sw_in`  input  W: raw, asynchronous switch levels.
- `sw_db`  output  W: debounced level per channel.
- `rise_tick`  output  W: one-cycle pulse when `sw_db[i]` goes 0→1.
- `fall_tick`  output  W: one-cycle pulse when `sw_db[i]` goes 1→0.

## Operation
- Per channel, `sw_in[i]` passes through two flops to give `s[i]`. The FSM acts only on `s[i]`.
- FSM states are ZERO, WAIT1, ONE and WAIT0. The counter `cnt` is N bits, unsigned.
- **ZERO:** if `s=1`, go to WAIT1 and load `cnt = 2^N-1`. Otherwise stay.
- **WAIT1:**
  - If `s=0`, go to ZERO; no tick.
  - Else if `cnt==0`, go to ONE and pulse `rise_tick`.
  - Else decrement `cnt`.
- **ONE:** if `s=0`, go to WAIT0 and load `cnt = 2^N-1`.
- **WAIT0:**
  - If `s=1`, go to ONE; no tick.
  - Else if `cnt==0`, go to ZERO and pulse `fall_tick`.
  - Else decrement `cnt`.
- `sw_db[i]` is 1 in ONE and WAIT0, and 0 in ZERO and WAIT1. It is registered and changes only together with the state.
- `cnt` never wraps. It is only decremented when nonzero and only reloaded on entry to a WAIT state.
- Channels are fully independent. Simultaneous events on different channels are each handled in the same cycle.
- A glitch shorter than the window (any bounce back to the old level during WAIT) restarts from the stable state. A later re-entry to WAIT reloads the full window.

## Timing
- Reset values:
  - synchroniser flops: 0
  - FSM state: ZERO
  - `cnt`: 0
  - `sw_db`: 0
  - `rise_tick`, `fall_tick`: 0
- Reset asserted mid-window returns the channel to ZERO immediately and drops `sw_db` asynchronously. No tick is emitted on reset.
- Latency from a clean level change first sampled at edge k: `sw_db` and the tick change at edge k+2+2^N. The tick is high for exactly one cycle.
- A switch held high through reset release produces `sw_db=1` and one `rise_tick` 2+2^N cycles after release.
- At most one of `rise_tick[i]` / `fall_tick[i]` is high in any cycle.
- Minimum spacing between ticks on one channel is 2^N+1 cycles.

## Structure
- Shared package `sw_db_pkg` holds:
  - `typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t`
  - default constants `DB_N_DEFAULT = 20` and `DB_W_DEFAULT = 2`.
- Sub-module `debounce_ch #(N)` implements one channel: synchroniser, FSM, counter and registered outputs.
- `sw_debouncer` is a generate loop of W instances.
- `sw_db[0]` and `sw_db[1]` drive the display stage's enable and direction inputs at the top level.

## Test plan
Bench uses `N=3`, so the window is 8 cycles.
- **Reset:** assert `reset_n=0` mid-WAIT1 → `sw_db=0`, ticks 0, state ZERO; after release with `sw_in=0`, outputs stay 0 for 50 cycles.
- **Clean rise:** `sw_in[0]` 0→1 sampled at edge 10 → `sw_db[0]=1` and `rise_tick[0]=1` at edge 20 only; `sw_db[1]` unchanged.
- **Bounce:** `sw_in[0]` toggles 1,0,1,0 every 3 cycles, then holds 1 → no tick during the toggles; a single `rise_tick` 10 cycles after the final 0→1 sample.
- **Clean fall:** from ONE, `sw_in[0]` 1→0 at edge 40 → `sw_db[0]=0` and `fall_tick[0]=1` at edge 50; a 5-cycle low pulse instead yields no tick and `sw_db` stays 1.
- **Simultaneous channels:** both channels rise on the same edge → both `rise_tick` bits pulse in the same cycle, exactly once.
- **Held through reset:** `sw_in=2'b11` during reset, released at edge 0 → `sw_db=2'b11` and `rise_tick=2'b11` at edge 10.

Source files
------------

// File: rtl/sw_db_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sw_db_pkg : shared state type and default sizes for the switch debouncer |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package sw_db_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int DB_N_DEFAULT = 20;
    localparam int DB_W_DEFAULT = 2;

endpackage : sw_db_pkg
`default_nettype wire

// File: rtl/sw_debouncer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sw_debouncer_if : raw switch levels in, debounced levels and ticks out   |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
interface sw_debouncer_if #(
    parameter int W = 2
);
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_db;
    logic [W-1:0] rise_tick;
    logic [W-1:0] fall_tick;

    modport master (
        output sw_in,
        input  sw_db,
        input  rise_tick,
        input  fall_tick
    );

    modport slave (
        input  sw_in,
        output sw_db,
        output rise_tick,
        output fall_tick
    );

endinterface : sw_debouncer_if
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_ch : one channel - 2-flop synchroniser, 4-state FSM, counter    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module debounce_ch
    import sw_db_pkg::*;
#(
    parameter int N = DB_N_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic sw_i,
    output logic      db_o,
    output logic      rise_o,
    output logic      fall_o
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   sync_q;
    db_state_t    state_q;
    logic [N-1:0] cnt_q;
    logic         db_q;
    logic         rise_q;
    logic         fall_q;
    logic         s;

    assign s = sync_q[1];

    // Ticks default low every cycle so each one lasts exactly one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b00;
            state_q <= ZERO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sw_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ZERO: begin
                    if (s) begin
                        state_q <= WAIT1;
                        cnt_q   <= CNT_MAX;
                    end
                end
                WAIT1: begin
                    if (!s) begin
                        state_q <= ZERO;
                    end else if (cnt_q == '0) begin
                        state_q <= ONE;
                        db_q    <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ONE: begin
                    if (!s) begin
                        state_q <= WAIT0;
                        cnt_q   <= CNT_MAX;
                    end
                end
                WAIT0: begin
                    if (s) begin
                        state_q <= ONE;
                    end else if (cnt_q == '0) begin
                        state_q <= ZERO;
                        db_q    <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ZERO;
                    db_q    <= 1'b0;
                end
            endcase
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule : debounce_ch
`default_nettype wire

// File: rtl/sw_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sw_debouncer : W independent debounce channels feeding the display stage |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module sw_debouncer
    import sw_db_pkg::*;
#(
    parameter int W = DB_W_DEFAULT,
    parameter int N = DB_N_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    sw_debouncer_if.slave bus
);

    logic [W-1:0] ch_db;
    logic [W-1:0] ch_rise;
    logic [W-1:0] ch_fall;

    generate
        for (genvar i = 0; i < W; i++) begin : g_ch
            debounce_ch #(
                .N (N)
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .sw_i    (bus.sw_in[i]),
                .db_o    (ch_db[i]),
                .rise_o  (ch_rise[i]),
                .fall_o  (ch_fall[i])
            );
        end : g_ch
    endgenerate

    // Bits 0 and 1 become the display stage's enable and direction.
    assign bus.sw_db     = ch_db;
    assign bus.rise_tick = ch_rise;
    assign bus.fall_tick = ch_fall;

endmodule : sw_debouncer
`default_nettype wire

// File: tb/tb_sw_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sw_debouncer : directed and random stimulus against a run-length model|
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_sw_debouncer;

    localparam int W   = 2;
    localparam int N   = 3;
    localparam int WIN = 1 << N;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sw_debouncer_if #(.W(W)) bus ();

    sw_debouncer #(
        .W (W),
        .N (N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Level flips once the synchronised input has disagreed with it for WIN+1 edges in a row.
    logic [W-1:0] m_h1, m_h2, m_db, m_rise, m_fall;
    int           m_run [W];

    int edge_idx, rise0_at, fall0_at, both_at;
    int rise0_cnt, rise1_cnt, fall0_cnt, both_cnt;

    logic [W-1:0] rv;
    int           hold [W];

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
        for (int c = 0; c < W; c++) m_run[c] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        if (!reset_n) begin
            model_reset();
        end else begin
            s    = m_h2;
            m_h2 = m_h1;
            m_h1 = bus.sw_in;
            for (int c = 0; c < W; c++) begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (s[c] != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == WIN + 1) begin
                        m_db[c] = ~m_db[c];
                        if (m_db[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (bus.sw_db === m_db) else begin
            errors++;
            $error("FAIL sw_db: observed=%b expected=%b t=%0t", bus.sw_db, m_db, $time);
        end
        checks++;
        assert (bus.rise_tick === m_rise) else begin
            errors++;
            $error("FAIL rise_tick: observed=%b expected=%b t=%0t", bus.rise_tick, m_rise, $time);
        end
        checks++;
        assert (bus.fall_tick === m_fall) else begin
            errors++;
            $error("FAIL fall_tick: observed=%b expected=%b t=%0t", bus.fall_tick, m_fall, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        edge_idx = 0; rise0_at = -1; fall0_at = -1; both_at = -1;
        rise0_cnt = 0; rise1_cnt = 0; fall0_cnt = 0; both_cnt = 0;
    endtask

    task automatic step(input logic [W-1:0] v);
        bus.sw_in = v;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (bus.rise_tick[0] === 1'b1) begin
            rise0_cnt++;
            if (rise0_at < 0) rise0_at = edge_idx;
        end
        if (bus.fall_tick[0] === 1'b1) begin
            fall0_cnt++;
            if (fall0_at < 0) fall0_at = edge_idx;
        end
        if (bus.rise_tick[1] === 1'b1) rise1_cnt++;
        if (bus.rise_tick === 2'b11) begin
            both_cnt++;
            if (both_at < 0) both_at = edge_idx;
        end
        edge_idx++;
    endtask

    task automatic steps(input logic [W-1:0] v, input int n);
        for (int k = 0; k < n; k++) step(v);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.sw_in = 2'b11;
        model_reset();
        clear_stats();

        // Held high through reset: both channels rise 10 edges after release.
        steps(2'b11, 3);
        check_int("reset_db", int'(bus.sw_db), 0);
        release_reset();
        clear_stats();
        steps(2'b11, 15);
        check_int("held_rise_edge", both_at, 10);
        check_int("held_rise_count", both_cnt, 1);

        // Both low, then clean rise on channel 0 only.
        steps(2'b00, 12);
        clear_stats();
        steps(2'b01, 14);
        check_int("clean_rise_edge", rise0_at, 10);
        check_int("clean_rise_count", rise0_cnt, 1);
        check_int("clean_rise_ch1", rise1_cnt, 0);

        // Clean fall on channel 0.
        clear_stats();
        steps(2'b00, 14);
        check_int("clean_fall_edge", fall0_at, 10);
        check_int("clean_fall_count", fall0_cnt, 1);

        // Five-cycle low pulse from ONE is absorbed.
        steps(2'b01, 14);
        clear_stats();
        steps(2'b00, 5);
        steps(2'b01, 15);
        check_int("short_low_falls", fall0_cnt, 0);
        check_int("short_low_db", int'(bus.sw_db[0]), 1);

        // Bounce: toggles every 3 cycles give no tick, then one rise after the hold.
        steps(2'b00, 14);
        clear_stats();
        steps(2'b01, 3); steps(2'b00, 3); steps(2'b01, 3); steps(2'b00, 3);
        check_int("bounce_no_tick", rise0_cnt, 0);
        clear_stats();
        steps(2'b01, 15);
        check_int("bounce_rise_edge", rise0_at, 10);
        check_int("bounce_rise_count", rise0_cnt, 1);

        // Simultaneous rise on both channels.
        steps(2'b00, 14);
        clear_stats();
        steps(2'b11, 14);
        check_int("simul_both_edge", both_at, 10);
        check_int("simul_both_count", both_cnt, 1);
        check_int("simul_rise0_count", rise0_cnt, 1);
        check_int("simul_rise1_count", rise1_cnt, 1);

        // Reset mid-WAIT0 drops sw_db without waiting for a clock.
        steps(2'b00, 5);
        check_int("pre_reset_db", int'(bus.sw_db), 3);
        assert_reset();
        check_int("async_reset_db", int'(bus.sw_db), 0);
        steps(2'b00, 2);
        release_reset();
        clear_stats();
        steps(2'b00, 50);
        check_int("post_reset_rises", rise0_cnt + rise1_cnt, 0);
        check_int("post_reset_falls", fall0_cnt, 0);
        check_int("post_reset_db", int'(bus.sw_db), 0);

        // Reset mid-WAIT1.
        steps(2'b11, 5);
        assert_reset();
        check_int("wait1_reset_db", int'(bus.sw_db), 0);
        steps(2'b00, 2);
        release_reset();

        // Random hold lengths straddling the window.
        rv = bus.sw_in;
        for (int c = 0; c < W; c++) hold[c] = 0;
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    rv[c]   = ~rv[c];
                    hold[c] = int'($urandom_range(1, 14));
                end
                hold[c]--;
            end
            step(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sw_debouncer
`default_nettype wire
